pet_status_fsm: RTL

Consumes the six 4-bit need levels produced by the stats stage and derives the pet's overall condition. Outputs feed the display/sprite selector and the buzzer driver.
- Need convention: 0 = fully satisfied, 15 = worst.
- Tracks mood, a worst-need indicator, a user-acknowledgeable alert, pet age in ticks, and a terminal death condition.

---
 rtl/pet_status_fsm.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pet_status_fsm.sv
// Derives the pet's overall condition (mood, alert, age, death) from the six 4-bit need levels.
// Worst-need stage is registered; the mood FSM runs from those registered values.
module pet_status_fsm #(
  parameter int unsigned TICK_DIV   = 27_000_000,
  parameter int unsigned NEED_TH    = 10,
  parameter int unsigned CRIT_TH    = 15,
  parameter int unsigned SLEEP_TH   = 12,
  parameter int unsigned WAKE_TH    = 8,
  parameter int unsigned SICK_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hunger,
  input  logic [3:0] happiness,
  input  logic [3:0] health,
  input  logic [3:0] hygiene,
  input  logic [3:0] energy,
  input  logic [3:0] social,
  input  logic       ack,
  output logic [2:0] mood,
  output logic       alert,
  output logic [2:0] worst_stat,
  output logic [3:0] worst_level,
  output logic [7:0] age,
  output logic       dead
);

  localparam int unsigned PrescW = $clog2(TICK_DIV);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);
  localparam logic [3:0] NeedTh   = 4'(NEED_TH);
  localparam logic [3:0] CritTh   = 4'(CRIT_TH);
  localparam logic [3:0] SleepTh  = 4'(SLEEP_TH);
  localparam logic [3:0] WakeTh   = 4'(WAKE_TH);
  localparam logic [3:0] SickLim  = 4'(SICK_LIMIT);

  typedef enum logic [2:0] {
    StHappy    = 3'd0,
    StNeedy    = 3'd1,
    StSleeping = 3'd2,
    StSick     = 3'd3,
    StDead     = 3'd4
  } mood_e;

  // Prescaler
  logic [PrescW-1:0] presc_q;
  logic              tick;

  assign tick = (presc_q == PrescMax);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Worst-need stage
  logic [5:0][3:0] need;
  logic [3:0]      wl_d, wl_q;
  logic [2:0]      ws_d, ws_q;
  logic            crit_other_d, crit_other_q;
  logic [3:0]      energy_q;

  assign need = {social, energy, hygiene, health, happiness, hunger};

  always_comb begin
    wl_d         = need[0];
    ws_d         = 3'd0;
    crit_other_d = 1'b0;
    // Strict compare keeps the lowest index on ties.
    for (int i = 1; i < 6; i++) begin
      if (need[i] > wl_d) begin
        wl_d = need[i];
        ws_d = 3'(i);
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (i != 4 && need[i] >= CritTh) crit_other_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wl_q         <= '0;
      ws_q         <= '0;
      crit_other_q <= 1'b0;
      energy_q     <= '0;
    end else begin
      wl_q         <= wl_d;
      ws_q         <= ws_d;
      crit_other_q <= crit_other_d;
      energy_q     <= energy;
    end
  end

  // Mood FSM
  mood_e      state_d, state_q;
  logic [3:0] crit_d, crit_q;
  logic       alert_d, alert_q;
  logic [7:0] age_d, age_q;
  logic       dead_q;

  always_comb begin
    state_d = state_q;
    crit_d  = crit_q;
    alert_d = alert_q;
    age_d   = age_q;

    case (state_q)
      StHappy: begin
        if (wl_q >= CritTh)         state_d = StSick;
        else if (energy_q >= SleepTh) state_d = StSleeping;
        else if (wl_q >= NeedTh)    state_d = StNeedy;
      end
      StNeedy: begin
        if (wl_q >= CritTh)         state_d = StSick;
        else if (energy_q >= SleepTh) state_d = StSleeping;
        else if (wl_q < NeedTh)     state_d = StHappy;
      end
      StSleeping: begin
        if (crit_other_q)           state_d = StSick;
        else if (energy_q < WakeTh) state_d = StHappy;
      end
      StSick: begin
        if (wl_q < CritTh) begin
          state_d = StNeedy;
          crit_d  = '0;
        end else if (tick) begin
          crit_d = crit_q + 4'd1;
          if (crit_d == SickLim) state_d = StDead;
        end
      end
      StDead:  state_d = StDead;
      default: state_d = StHappy;
    endcase

    if (state_d == StSick && state_q != StSick) crit_d = '0;

    // Entry beats a coincident ack; DEAD pins alert high.
    if (state_d == StDead) begin
      alert_d = 1'b1;
    end else if (state_d != state_q && (state_d == StNeedy || state_d == StSick)) begin
      alert_d = 1'b1;
    end else if (state_d != state_q && (state_d == StHappy || state_d == StSleeping)) begin
      alert_d = 1'b0;
    end else if (ack) begin
      alert_d = 1'b0;
    end

    if (tick && state_q != StDead && age_q != 8'hFF) age_d = age_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHappy;
      crit_q  <= '0;
      alert_q <= 1'b0;
      age_q   <= '0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crit_q  <= crit_d;
      alert_q <= alert_d;
      age_q   <= age_d;
      dead_q  <= (state_d == StDead);
    end
  end

  assign mood        = state_q;
  assign alert       = alert_q;
  assign worst_stat  = ws_q;
  assign worst_level = wl_q;
  assign age         = age_q;
  assign dead        = dead_q;

endmodule
